// File: rtl/cspi_pkg.sv
// Shared encodings for the SPI command controller: FSM state codes, command
// layout and the fixed return bytes.
package cspi_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_DATA  = 3'd1;
  localparam logic [2:0] ST_WR_SUM   = 3'd2;
  localparam logic [2:0] ST_WR_REQ   = 3'd3;
  localparam logic [2:0] ST_RD_REQ   = 3'd4;
  localparam logic [2:0] ST_RD_DUMMY = 3'd5;

  localparam int         CMD_WR_BIT = 7;
  localparam logic [7:0] RD_TO_VAL  = 8'hEE;
  localparam logic [7:0] CTRL_Q_RST = 8'hFF;

  // States in which the controller is waiting on the SPI master for a byte.
  function automatic logic is_frame_state(input logic [2:0] st);
    return (st == ST_WR_DATA) || (st == ST_WR_SUM) || (st == ST_RD_DUMMY);
  endfunction

endpackage

// File: rtl/cspi_cmd_ctrl_if.sv
// Register-file bus between the SPI command controller (master) and the
// register file (slave).
interface cspi_cmd_ctrl_if;
  // reg_wr / reg_rd are levels held by the master until reg_ack (one cycle,
  // slave) or until the master gives up; reg_rdata is valid only with reg_ack.
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;

  modport master (output reg_addr, reg_wdata, reg_wr, reg_rd,
                  input  reg_rdata, reg_ack);
  modport slave  (input  reg_addr, reg_wdata, reg_wr, reg_rd,
                  output reg_rdata, reg_ack);
endinterface

// File: rtl/cyc_timer.sv
// Cycle timer: counts enabled cycles and pulses tc on the LIMIT-th one.
// clr has priority over en and suppresses tc.
module cyc_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign tc = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cspi_cmd_ctrl.sv
// SPI command decoder driving a register-file bus. Optional write checksum
// byte is built in when CSPI_CMD_SUM_EN is defined.
module cspi_cmd_ctrl
  import cspi_pkg::*;
#(
  parameter int FRAME_TO = 1_000_000,
  parameter int ACK_TO   = 255
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic [7:0]              ctrl_data,
  input  logic                    ctrl_dvld,
  output logic [7:0]              ctrl_q,
  output logic                    ctrl_qvld,
  cspi_cmd_ctrl_if.master         reg_bus,
  output logic [7:0]              err_cnt,
  output logic                    busy,
  output logic [2:0]              dbg_state
);
  logic [2:0] state;
  logic [7:0] q_r, wdata_r, err_r;
  logic [6:0] addr_r;
  logic       qvld_r, wr_r, rd_r;
  logic       in_frame, in_req, frame_tc, ack_tc, sum_bad, err_ev;

  assign in_frame = is_frame_state(state);
  assign in_req   = (state == ST_WR_REQ) || (state == ST_RD_REQ);

  // A received byte restarts the frame timer; an ack stops the ack timer.
  cyc_timer #(.LIMIT(FRAME_TO)) u_frame_tmr (
    .clk(clk_sys), .rst(rst), .clr(!in_frame || ctrl_dvld), .en(in_frame), .tc(frame_tc)
  );
  cyc_timer #(.LIMIT(ACK_TO)) u_ack_tmr (
    .clk(clk_sys), .rst(rst), .clr(!in_req || reg_bus.reg_ack), .en(in_req), .tc(ack_tc)
  );

`ifdef CSPI_CMD_SUM_EN
  assign sum_bad = (state == ST_WR_SUM) && ctrl_dvld &&
                   (ctrl_data != ({1'b1, addr_r} ^ wdata_r));
`else
  assign sum_bad = 1'b0;
`endif

  // Coinciding error sources collapse into a single increment.
  assign err_ev = frame_tc || ack_tc || (in_req && ctrl_dvld) || sum_bad;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state   <= ST_IDLE;
      q_r     <= CTRL_Q_RST;
      qvld_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
    end else begin
      qvld_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctrl_dvld) begin
            addr_r <= ctrl_data[6:0];
            if (ctrl_data[CMD_WR_BIT]) begin
              state <= ST_WR_DATA;
            end else begin
              state <= ST_RD_REQ;
              rd_r  <= 1'b1;
            end
          end
        end
        ST_WR_DATA: begin
          if (ctrl_dvld) begin
            wdata_r <= ctrl_data;
`ifdef CSPI_CMD_SUM_EN
            state   <= ST_WR_SUM;
`else
            state   <= ST_WR_REQ;
            wr_r    <= 1'b1;
`endif
          end else if (frame_tc) begin
            state <= ST_IDLE;
          end
        end
`ifdef CSPI_CMD_SUM_EN
        ST_WR_SUM: begin
          if (ctrl_dvld) begin
            if (sum_bad) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WR_REQ;
              wr_r  <= 1'b1;
            end
          end else if (frame_tc) begin
            state <= ST_IDLE;
          end
        end
`endif
        ST_WR_REQ: begin
          if (reg_bus.reg_ack || ack_tc) begin
            wr_r  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          // The master always gets a return byte, even when the read times out.
          if (reg_bus.reg_ack || ack_tc) begin
            rd_r   <= 1'b0;
            q_r    <= reg_bus.reg_ack ? reg_bus.reg_rdata : RD_TO_VAL;
            qvld_r <= 1'b1;
            state  <= ST_RD_DUMMY;
          end
        end
        ST_RD_DUMMY: begin
          if (ctrl_dvld || frame_tc) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      err_r <= '0;
    end else if (err_ev && (err_r != 8'hFF)) begin
      err_r <= err_r + 8'd1;
    end
  end

  assign ctrl_q            = q_r;
  assign ctrl_qvld         = qvld_r;
  assign reg_bus.reg_addr  = addr_r;
  assign reg_bus.reg_wdata = wdata_r;
  assign reg_bus.reg_wr    = wr_r;
  assign reg_bus.reg_rd    = rd_r;
  assign err_cnt           = err_r;
  assign busy              = (state != ST_IDLE);
  assign dbg_state         = state;
endmodule

// File: doc/cspi_cmd_ctrl.md
CSPI_CMD_CTRL -- requirements
Module: cspi_cmd_ctrl

Interface
REQ-001 SHALL have parameter FRAME_TO, default 1_000_000, inter-byte frame timeout in clk_sys cycles (10 ms at 100 MHz).
REQ-002 SHALL have parameter ACK_TO, default 255, maximum cycles to wait for reg_ack.
REQ-003 SHALL have port clk_sys  in  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port ctrl_data  in  8  received SPI byte, valid with ctrl_dvld.
REQ-006 SHALL have port ctrl_dvld  in  1  one-cycle strobe per received byte.
REQ-007 SHALL have port ctrl_q  out  8  byte to load into the SPI return shifter.
REQ-008 SHALL have port ctrl_qvld  out  1  one-cycle load strobe for ctrl_q.
REQ-009 SHALL have port reg_addr  out  7  register address.
REQ-010 SHALL have port reg_wdata  out  8  write data.
REQ-011 SHALL have port reg_wr  out  1  write request, level, held until ack or timeout.
REQ-012 SHALL have port reg_rd  out  1  read request, level, held until ack or timeout.
REQ-013 SHALL have port reg_rdata  in  8  read data, sampled when reg_ack=1.
REQ-014 SHALL have port reg_ack  in  1  one-cycle completion from the register file.
REQ-015 SHALL have port err_cnt  out  8  saturating protocol-error counter.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL treat byte0 as the command: bit7=1 write, bit7=0 read, bits6:0 address.
REQ-018 SHALL implement states IDLE, WR_DATA, WR_SUM (macro only), WR_REQ, RD_REQ, RD_DUMMY.
REQ-019 SHALL on a command byte in IDLE latch reg_addr and go to WR_DATA (write) or RD_REQ (read) next cycle.
REQ-020 SHALL in WR_DATA on ctrl_dvld latch reg_wdata and enter WR_REQ, asserting reg_wr the following cycle.
REQ-021 SHALL in RD_REQ assert reg_rd; on reg_ack drive ctrl_q=reg_rdata with ctrl_qvld for exactly one cycle (cycle after ack), then enter RD_DUMMY.
REQ-022 SHALL in RD_DUMMY consume and discard the next byte (the master's clock-out byte), then return to IDLE.
REQ-023 SHALL in WR_REQ deassert reg_wr and return to IDLE the cycle after reg_ack.
REQ-024 SHALL on ACK_TO cycles without reg_ack drop the request, increment err_cnt, and for a read still return ctrl_q=0xEE with ctrl_qvld, entering RD_DUMMY.
REQ-025 SHALL abort to IDLE and increment err_cnt when no ctrl_dvld arrives within FRAME_TO cycles in WR_DATA, WR_SUM or RD_DUMMY.
REQ-026 SHALL drop any ctrl_dvld received in WR_REQ or RD_REQ and increment err_cnt.
REQ-027 SHALL give ctrl_dvld priority when it coincides with frame-timeout expiry (byte accepted, no error).
REQ-028 SHALL saturate err_cnt at 0xFF; if two error events coincide, err_cnt increments by one.
REQ-029 SHALL never assert reg_wr and reg_rd together.

Reset
REQ-030 SHALL on rst=1 at a clock edge force IDLE, ctrl_q=0xFF, ctrl_qvld=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, err_cnt=0, busy=0, timers cleared.
REQ-031 SHALL abandon any in-flight request on reset mid-frame without issuing reg_wr/reg_rd afterwards.

Configuration
REQ-032 SHALL, with CSPI_CMD_SUM_EN defined, require a third write byte equal to XOR of byte0 and byte1 (state WR_SUM); on mismatch discard the write, increment err_cnt, return to IDLE.
REQ-033 SHALL, without CSPI_CMD_SUM_EN, omit WR_SUM and issue writes after byte1; reads are unaffected either way.

Structure
REQ-034 SHALL place the state encoding, command bit index (7), timeout-read value 0xEE and reset ctrl_q value 0xFF in shared package cspi_pkg.
REQ-035 SHALL implement both timeouts with one reusable sub-module cyc_timer (clear, enable, terminal-count pulse), instantiated twice.

Verification
REQ-036 SHALL cover write: bytes 0x85,0x3C -> reg_wr with reg_addr=0x05, reg_wdata=0x3C; ack after 3 cycles -> IDLE, err_cnt=0.
REQ-037 SHALL cover read: byte 0x12, reg_rdata=0xA7 with ack -> ctrl_q=0xA7, one-cycle ctrl_qvld; dummy byte 0x00 -> IDLE, no write issued.
REQ-038 SHALL cover ack timeout: read 0x12, reg_ack never -> reg_rd drops after 255 cycles, ctrl_q=0xEE, err_cnt=1.
REQ-039 SHALL cover frame timeout: 0x85 then silence for FRAME_TO (set to 100) -> IDLE, no reg_wr, err_cnt=1; coinciding byte at cycle 100 -> accepted.
REQ-040 SHALL cover checksum (macro on): 0x85,0x3C,0xB9 -> write issued; 0x85,0x3C,0x00 -> no write, err_cnt=1.
REQ-041 SHALL cover rst asserted during RD_REQ -> all outputs at reset values next cycle, no ctrl_qvld afterwards.
